// File: rtl/seg_pkg.sv
// seg_pkg: shared types and defaults for the display frame scheduler.
// Holds the FSM state enum, the frame bundle and the counter width helper.
package seg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } seg_sched_state_t;

    typedef struct packed {
        logic [31:0] hexs;
        logic [7:0]  point;
        logic [7:0]  les;
        logic        tex;
    } seg_frame_t;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_REFRESH_CYCLES = 1_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 256;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_FLASH_HALF     = 25_000_000;

    // A bound of 1 still needs a 1-bit counter.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Search begins one past the last winner and wraps modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_frame_sched.sv
// seg_frame_sched: arbitrates display requesters, latches the frame and
// drives serializer start pulses, periodic refresh and the blink clock.
module seg_frame_sched
    import seg_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int FLASH_HALF     = DEF_FLASH_HALF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [32*N_REQ-1:0]      hexs_in,
    input  logic [8*N_REQ-1:0]       point_in,
    input  logic [8*N_REQ-1:0]       les_in,
    input  logic [N_REQ-1:0]         tex_in,
    input  logic                     frame_done,
    output logic [N_REQ-1:0]         ack,
    output logic                     Start,
    output logic [31:0]              Hexs,
    output logic [7:0]               point,
    output logic [7:0]               LES,
    output logic                     Tex,
    output logic                     flash,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int RW = cnt_w(REFRESH_CYCLES);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int GW = cnt_w(GAP_CYCLES);
    localparam int FW = cnt_w(FLASH_HALF);

    localparam logic [RW-1:0] RF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_HALF - 1);

    seg_sched_state_t state;
    seg_frame_t       frame;
    seg_frame_t       sel_frame;

    logic [RW-1:0]    refresh_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [FW-1:0]    flash_cnt;
    logic [IW-1:0]    last_owner;
    logic [IW-1:0]    pend;

    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req),
        .last  (last_owner),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) grant_idx = IW'(i);
    end

    // Winner chosen at the IDLE edge; its data is captured one cycle later.
    always_comb begin
        sel_frame = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pend == IW'(i)) begin
                sel_frame.hexs  = hexs_in[32*i +: 32];
                sel_frame.point = point_in[8*i +: 8];
                sel_frame.les   = les_in[8*i +: 8];
                sel_frame.tex   = tex_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            frame       <= '0;
            refresh_cnt <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            last_owner  <= IW'(N_REQ - 1);
            pend        <= '0;
            owner       <= '0;
            ack         <= '0;
            Start       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack   <= '0;
            Start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        state <= S_LOAD;
                        pend  <= grant_idx;
                        ack   <= grant;
                        busy  <= 1'b1;
                    end else if (refresh_cnt == RF_LAST) begin
                        state <= S_START;
                        Start <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    frame      <= sel_frame;
                    owner      <= pend;
                    last_owner <= pend;
                    Start      <= 1'b1;
                    state      <= S_START;
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_done) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        refresh_cnt <= '0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt <= '0;
            flash     <= 1'b0;
        end else if (flash_cnt == FL_LAST) begin
            flash_cnt <= '0;
            flash     <= ~flash;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end

    assign Hexs  = frame.hexs;
    assign point = frame.point;
    assign LES   = frame.les;
    assign Tex   = frame.tex;

endmodule

// File: doc/seg_frame_sched.md
# seg_frame_sched

Frame scheduler in front of the 7-segment display datapath (`Display`: text/hex encoder plus the 64-bit P2S serializer). It arbitrates up to N_REQ requesters that want to show a value, latches the winning frame, issues one-cycle `Start` pulses to the serializer, and waits for completion or timeout. When nothing new is requested it periodically re-sends the last frame. It also generates the blink `flash` square wave.

## Interface
Parameters:
- `N_REQ`, 4: number of requester channels (2..8).
- `REFRESH_CYCLES`, 1_000_000: idle cycles before the last frame is re-sent.
- `TIMEOUT_CYCLES`, 256: maximum WAIT duration before the frame is abandoned.
- `GAP_CYCLES`, 4: dead cycles after each frame before the next arbitration.
- `FLASH_HALF`, 25_000_000: half-period of `flash`, in clocks.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in N_REQ: per-channel request level; held until `ack`.
- `hexs_in` in 32*N_REQ: channel i occupies bits [32i+31:32i].
- `point_in` in 8*N_REQ: per-channel decimal points.
- `les_in` in 8*N_REQ: per-channel digit blink enables.
- `tex_in` in N_REQ: per-channel text/hex mode select.
- `frame_done` in 1: one-cycle pulse from the serializer when the 64-bit shift completes.
- `ack` out N_REQ: one-hot, one-cycle pulse to the granted channel.
- `Start` out 1: serializer start pulse.
- `Hexs` out 32, `point` out 8, `LES` out 8, `Tex` out 1: latched frame to `Display`.
- `flash` out 1: blink clock.
- `busy` out 1: high in LOAD, START, WAIT and GAP.
- `owner` out $clog2(N_REQ): channel of the latched frame.
- `timeout_err` out 1: sticky; set on timeout, cleared only by `rst`.

## Operation
- States: IDLE, LOAD, START, WAIT, GAP.
- IDLE:
  - If any `req` bit is high, go to LOAD.
  - Else, if the refresh counter equals REFRESH_CYCLES-1, go to START with no ack; the latched frame is re-sent.
  - Otherwise stay in IDLE.
- Arbitration is round-robin. Search starts at `last_owner+1` mod N_REQ; the first high `req` wins.
- LOAD:
  - Latch the winner's hexs/point/LES/tex into the output registers.
  - Set `owner` and `last_owner`, pulse `ack[winner]`, go to START.
- START: `Start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On `frame_done`, go to GAP.
  - When the wait counter reaches TIMEOUT_CYCLES-1, set `timeout_err` and go to GAP.
- GAP: hold for GAP_CYCLES cycles, then go to IDLE.
- The refresh counter resets to 0 on every exit from GAP and counts only in IDLE.
- `Hexs`/`point`/`LES`/`Tex` change only in LOAD. They stay stable from the edge after LOAD until the next LOAD.
- `flash` toggles every FLASH_HALF cycles, free-running and independent of the FSM.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `Start`, `ack`, `busy`, `flash`, `timeout_err` = 0.
  - `Hexs`, `point`, `LES` = 0; `Tex` = 0; `owner` = 0.
  - `last_owner` = N_REQ-1, so channel 0 has first priority.
- Request latency: `req` high in IDLE at cycle T gives `ack` at T+1 (LOAD) and `Start` at T+2. New data is visible at T+2, the same cycle as `Start`.
- A request arriving during a frame waits; it is granted in the first IDLE cycle after GAP.
- `req` dropped before grant: no ack is issued. A request held after its ack is treated as a new request.
- `frame_done` is ignored outside WAIT, including in the START cycle.
- `frame_done` in the cycle the timeout would fire: done wins, and `timeout_err` is not set.
- Counter widths: $clog2 of each bound. All counters saturate-free and wrap only via explicit clears.
- `rst` mid-frame: next edge returns to IDLE with all reset values. The latched frame is lost, and an in-flight `ack` does not repeat.

## Structure
- Shared package `seg_pkg` holds:
  - the state enum `seg_sched_state_t`;
  - the frame typedef `seg_frame_t` (hexs 32, point 8, les 8, tex 1);
  - the default parameter constants.
- One sub-module, `rr_arbiter` (N, req, last, grant one-hot, valid). It is combinational and reusable elsewhere.
- The FSM, counters, frame register and flash divider live in the top.

## Test plan
- Single request: ch2 `req`, hexs=0x1234ABCD, point=0x0F, tex=1 → `ack`=0100 one cycle later; `Start` one cycle after that with `Hexs`=0x1234ABCD and `Tex`=1; `frame_done` 40 cycles later → `busy` falls after GAP_CYCLES.
- Round-robin: all four `req` held continuously → grants in order 0,1,2,3,0. Each `Start` is separated by WAIT+GAP, and no channel is granted twice in a row.
- Timeout: withhold `frame_done` → `timeout_err`=1 after TIMEOUT_CYCLES in WAIT, FSM returns to IDLE, and a later request is served normally.
- Refresh: REFRESH_CYCLES=100, no requests → `Start` every ~100+frame cycles with an unchanged `Hexs` and no `ack`.
- Boundary cases:
  - `frame_done` on the final timeout cycle → no error flag.
  - `frame_done` pulsed in START → ignored.
  - `rst` asserted during WAIT → all outputs at reset values the next cycle.
- Flash: FLASH_HALF=10 → `flash` toggles every 10 cycles starting at 0, including across frames.
